aes_add_round_key_pipe: RTL and testbench
=========================================

// Module: aes_add_round_key_pipe
// PURPOSE
// Registered, flow-controlled AddRoundKey stage with an internal round-key store.
// Round keys are loaded once per key schedule. Each accepted state word is XORed
// with the key slot selected by its round index. Sits between the round datapath
// (SubBytes/ShiftRows/MixColumns) and the next round, and feeds the output register.
// A 2-entry output buffer keeps in_ready registered while sustaining 1 word/cycle.
// PARAMETERS
// DATA_W    128  state/key width in bits; multiple of 8, >= 8
// NUM_KEYS  15   round-key slots (15 = AES-256: rounds 0..14)
// IDX_W     4    round-index width; 2**IDX_W >= NUM_KEYS
// PORTS
// clk          in   1       rising-edge clock
// rst          in   1       synchronous, active-high reset
// key_wr_en    in   1       write key_wr_data into slot key_wr_idx
// key_wr_idx   in   IDX_W   key slot to write; writes with idx >= NUM_KEYS are ignored
// key_wr_data  in   DATA_W  round-key value
// key_clear    in   1       invalidate all key slots (loaded flags -> 0)
// in_valid     in   1       input word valid
// in_ready     out  1       block can accept a word (registered)
// in_data      in   DATA_W  state word
// in_round     in   IDX_W   round-key slot for this word
// in_bypass    in   1       1: pass in_data unmodified, no key lookup, no error
// out_valid    out  1       output word valid
// out_ready    in   1       downstream accepts output
// out_data     out  DATA_W  in_data ^ key[in_round], or pass-through
// out_err      out  1       qualifies out_data: slot out of range or not loaded
// BEHAVIOUR
// - Reset (rst=1 at edge): out_valid=0, out_data=0, out_err=0, in_ready=0 while rst
//   is high; in_ready=1 on the first cycle after rst falls.
// - Reset also clears the buffer count and all loaded flags. Key storage is not reset.
// - Input handshake: a word is accepted when in_valid & in_ready. The handshake
//   holds in_data, in_round and in_bypass stable only while in_valid=1 & in_ready=0.
// - Output handshake: a word retires when out_valid & out_ready. out_data and out_err
//   hold stable while out_valid=1 & out_ready=0.
// - Latency: a word accepted at edge N appears on out_valid/out_data after edge N
//   when the buffer was empty. Output order equals acceptance order.
// - Throughput: 1 word/cycle with out_ready=1.
// - Buffer: 2 entries. in_ready = (count<2) registered, where count is the value
//   after this edge. Accept and retire at the same edge leave count unchanged.
//   With count=2 and no retire, in_ready=0. No overflow and no drop is possible.
// - Datapath: byte-wise XOR across all DATA_W/8 bytes; no carries; bit i of out_data
//   depends only on bit i of the input and of the key.
// - Error rule, evaluated at acceptance: out_err=1 iff in_bypass=0 and either
//   in_round >= NUM_KEYS or loaded[in_round]=0.
//   When out_err=1, out_data=in_data unmodified.
// - Key write: the slot updates and loaded[idx] is set at the edge.
//   A word accepted in the same cycle and reading the same slot uses the OLD contents
//   and the OLD loaded flag. The new key applies from the next accepted word.
// - key_clear clears all loaded flags at the edge. If key_clear and key_wr_en occur
//   in the same cycle, the written slot ends loaded=1 and all others end 0.
// - Words already in the buffer are unaffected by later key writes or clears.
// - rst mid-stream: buffered words are discarded, with no output for them.
// TESTING
// 1 Load slot 0 = 000102030405060708090a0b0c0d0e0f, send 00112233445566778899aabbccddeeff
//   round 0 -> out 00102030405060708090a0b0c0d0e0f0, out_err=0, 1 cycle later.
// 2 Load slots 0..14 with random keys, stream 64 words back-to-back with out_ready=1
//   -> one output per cycle, in order, each equal to data^key[round].
// 3 Hold out_ready=0 and offer 3 words -> 2 accepted, in_ready=0, out_data stable.
//   Then raise out_ready -> the 3rd word is accepted and order is preserved.
// 4 round=15 with slot 3 never loaded, then round=3 -> both out_err=1, data unchanged.
//   With in_bypass=1 and round=15 -> out_err=0, data unchanged.
// 5 Write slot 2=FF..FF in the same cycle as word A5..A5 for round 2 (slot was 00..00)
//   -> out A5..A5. Next word A5..A5 -> 5A..5A.
// 6 Assert rst with 2 words buffered -> out_valid=0 next cycle, those words are never
//   emitted, and the loaded flags are cleared (round 0 word -> out_err=1).

Source files
------------

// File: rtl/aes_add_round_key_pipe.sv
// aes_add_round_key_pipe: registered AddRoundKey stage with an internal round-key store.
// Each accepted word is XORed with the key selected by its round index. It passes through
// unchanged, with out_err set, when the slot is out of range or not loaded.
// Latency: one edge from acceptance to out_valid when the buffer is empty.
// Backpressure: a 2-entry buffer; in_ready is registered as (count < 2) and gated low during rst.
// Ports:
//   clk, rst                               clock and synchronous active-high reset
//   key_wr_en/key_wr_idx/key_wr_data       round-key slot write
//   key_clear                              clear all loaded flags
//   in_valid/in_ready/in_data/in_round/in_bypass   input word handshake
//   out_valid/out_ready/out_data/out_err   output word handshake
module aes_add_round_key_pipe #(
  parameter int DATA_W   = 128,
  parameter int NUM_KEYS = 15,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              key_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_round,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  // Round-key storage and loaded flags.
  logic [DATA_W-1:0]   keys [NUM_KEYS];
  logic [NUM_KEYS-1:0] loaded;

  // Two-entry output buffer, circular. head points at the oldest word.
  logic [DATA_W-1:0] buf_data [2];
  logic [1:0]        buf_err;
  logic              head;
  logic [1:0]        count;
  logic [1:0]        count_nxt;
  logic              ready_q;

  logic              accept;
  logic              retire;
  logic              wr_ptr;
  logic [DATA_W-1:0] key_sel;
  logic              key_hit;
  logic              word_err;
  logic [DATA_W-1:0] word_data;

  // ready_q comes out of reset high. Gating it with rst keeps in_ready low while rst
  // is held, and lets in_ready rise in the first cycle after rst falls.
  assign in_ready  = ready_q & ~rst;
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;

  // An accept only happens when count < 2. The tail slot is therefore head + count mod 2.
  assign wr_ptr = head ^ count[0];

  // Key lookup. An index at or beyond NUM_KEYS matches no slot, so it reads as not loaded.
  // Reads see the pre-edge contents, so a same-cycle key write does not affect this word.
  always_comb begin
    key_sel = '0;
    key_hit = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (in_round == IDX_W'(k)) begin
        key_sel = keys[k];
        key_hit = loaded[k];
      end
    end
  end

  // The XOR is bitwise, so each byte lane is independent and no carries are involved.
  assign word_err  = ~in_bypass & ~key_hit;
  assign word_data = (in_bypass | word_err) ? in_data : (in_data ^ key_sel);

  always_comb begin
    count_nxt = count;
    unique case ({accept, retire})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 2'd0;
      head    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      count   <= count_nxt;
      ready_q <= (count_nxt != 2'd2);
      if (retire) head <= ~head;
    end
  end

  // Buffer payload needs no reset. It is only observed while count says it is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_data[wr_ptr] <= word_data;
      buf_err[wr_ptr]  <= word_err;
    end
  end

  // Key contents survive reset. Only the loaded flags are cleared.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (key_wr_en && (key_wr_idx == IDX_W'(k))) keys[k] <= key_wr_data;
    end
  end

  // If key_clear and a write land together, the written slot stays loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        loaded[k] <= (loaded[k] & ~key_clear) | (key_wr_en && (key_wr_idx == IDX_W'(k)));
      end
    end
  end

  assign out_data = out_valid ? buf_data[head] : '0;
  assign out_err  = out_valid & buf_err[head];

endmodule

// File: tb/tb_aes_add_round_key_pipe.sv
module tb_aes_add_round_key_pipe;
  localparam int DW = 128;
  localparam int NK = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_wr_en;
  logic [3:0]    key_wr_idx;
  logic [DW-1:0] key_wr_data;
  logic          key_clear;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [3:0]    in_round;
  logic          in_bypass;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;

  aes_add_round_key_pipe dut (
    .clk(clk), .rst(rst),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .key_clear(key_clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_round(in_round), .in_bypass(in_bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: key table, loaded flags, queue of expected outputs.
  logic [DW-1:0] keys_m   [16];
  bit            loaded_m [16];
  logic [DW:0]   exp_q    [$];   // {err, data}
  bit            last_acc;
  bit            last_ret;
  bit            hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_e;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW:0] model_word(input logic [DW-1:0] d, input int r, input bit byp);
    logic [DW-1:0] k;
    logic [DW-1:0] res;
    if (byp) return {1'b0, d};
    if (r >= NK || !loaded_m[r]) return {1'b1, d};
    k = keys_m[r];
    res = d;
    for (int b = 0; b < DW / 8; b++) res[b*8 +: 8] = d[b*8 +: 8] ^ k[b*8 +: 8];
    return {1'b0, res};
  endfunction

  // One clock cycle: check outputs at the falling edge, then update the model for the
  // coming rising edge. Returns 1 ns after that edge.
  task automatic step();
    logic [DW:0] e;
    @(negedge clk);
    if (rst) begin
      chk("rdy_in_rst", DW'(in_ready), DW'(0));
    end else begin
      chk("in_ready", DW'(in_ready), DW'(exp_q.size() < 2));
      chk("out_valid", DW'(out_valid), DW'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_data", out_data, exp_q[0][DW-1:0]);
        chk("out_err", DW'(out_err), DW'(exp_q[0][DW]));
      end
      if (hold_v) begin
        chk("stable_data", out_data, hold_d);
        chk("stable_err", DW'(out_err), DW'(hold_e));
      end
    end
    last_acc = !rst && in_valid && in_ready;
    last_ret = !rst && out_valid && out_ready;
    hold_v   = !rst && out_valid && !out_ready;
    hold_d   = out_data;
    hold_e   = out_err;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) loaded_m[i] = 1'b0;
    end else begin
      e = model_word(in_data, int'(in_round), in_bypass);
      if (last_ret) void'(exp_q.pop_front());
      if (last_acc) exp_q.push_back(e);
      if (key_clear) for (int i = 0; i < 16; i++) loaded_m[i] = 1'b0;
      if (key_wr_en && key_wr_idx < NK) begin
        keys_m[key_wr_idx]   = key_wr_data;
        loaded_m[key_wr_idx] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input int idx, input logic [DW-1:0] k);
    key_wr_en = 1'b1; key_wr_idx = 4'(idx); key_wr_data = k;
    step();
    key_wr_en = 1'b0;
  endtask

  // Offer one word until accepted, bounded.
  task automatic send_one(input logic [DW-1:0] d, input int r, input bit byp);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_round = 4'(r); in_bypass = byp;
    do begin
      step();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) chk("send_timeout", DW'(0), DW'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain", DW'(exp_q.size()), DW'(0));
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int n_acc;
    int n_ret;
    int wi;
    logic [DW-1:0] words [3];

    rst = 1'b1; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0; key_clear = 1'b0;
    in_valid = 1'b0; in_data = '0; in_round = '0; in_bypass = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin keys_m[i] = '0; loaded_m[i] = 1'b0; end

    // Reset state
    step(); step();
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_data", out_data, DW'(0));
    chk("rst_out_err", DW'(out_err), DW'(0));
    chk("rst_in_ready", DW'(in_ready), DW'(0));
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", DW'(in_ready), DW'(1));

    // Known-answer vector, one-cycle latency
    write_key(0, 128'h000102030405060708090a0b0c0d0e0f);
    send_one(128'h00112233445566778899aabbccddeeff, 0, 1'b0);
    chk("kat_valid", DW'(out_valid), DW'(1));
    chk("kat_data", out_data, 128'h00102030405060708090a0b0c0d0e0f0);
    chk("kat_err", DW'(out_err), DW'(0));
    drain();

    // All slots random, 64 back-to-back words
    for (int i = 0; i < NK; i++) write_key(i, rnd128());
    n_acc = 0; n_ret = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_data = rnd128(); in_round = 4'($urandom_range(0, NK - 1));
      in_bypass = 1'b0;
      step();
      if (last_acc) n_acc++;
      if (last_ret) n_ret++;
    end
    in_valid = 1'b0;
    step();
    if (last_ret) n_ret++;
    chk("stream_acc", DW'(n_acc), DW'(64));
    chk("stream_ret", DW'(n_ret), DW'(64));
    drain();

    // Backpressure: three words with out_ready low
    for (int i = 0; i < 3; i++) words[i] = rnd128();
    out_ready = 1'b0; wi = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_data = words[wi]; in_round = 4'(wi); in_bypass = 1'b0;
      step();
      if (last_acc) wi++;
    end
    chk("bp_accepted", DW'(wi), DW'(2));
    chk("bp_in_ready", DW'(in_ready), DW'(0));
    out_ready = 1'b1;
    for (int c = 0; c < 10 && wi < 3; c++) begin
      in_data = words[wi]; in_round = 4'(wi);
      step();
      if (last_acc) wi++;
    end
    in_valid = 1'b0;
    chk("bp_third", DW'(wi), DW'(3));
    drain();

    // Error cases after reset (slot 3 never loaded since)
    rst = 1'b1; step(); rst = 1'b0;
    send_one(128'h1234, 15, 1'b0);
    chk("err_r15", DW'(out_err), DW'(1));
    chk("err_r15_data", out_data, DW'(128'h1234));
    step();
    send_one(128'h5678, 3, 1'b0);
    chk("err_unloaded", DW'(out_err), DW'(1));
    chk("err_unl_data", out_data, DW'(128'h5678));
    step();
    send_one(128'h9abc, 15, 1'b1);
    chk("bypass_err", DW'(out_err), DW'(0));
    chk("bypass_data", out_data, DW'(128'h9abc));
    drain();

    // Same-cycle key write and key_clear interaction
    write_key(2, '0);
    key_wr_en = 1'b1; key_wr_idx = 4'd2; key_wr_data = {16{8'hFF}};
    in_valid = 1'b1; in_data = {16{8'hA5}}; in_round = 4'd2; in_bypass = 1'b0;
    step();
    key_wr_en = 1'b0; in_valid = 1'b0;
    chk("wr_same_acc", DW'(last_acc), DW'(1));
    chk("wr_same_old", out_data, {16{8'hA5}});
    step();
    send_one({16{8'hA5}}, 2, 1'b0);
    chk("wr_next_new", out_data, {16{8'h5A}});
    step();
    write_key(4, rnd128());
    key_clear = 1'b1; key_wr_en = 1'b1; key_wr_idx = 4'd5; key_wr_data = rnd128();
    step();
    key_clear = 1'b0; key_wr_en = 1'b0;
    send_one(rnd128(), 4, 1'b0);
    chk("clr_other", DW'(out_err), DW'(1));
    step();
    send_one(rnd128(), 5, 1'b0);
    chk("clr_written", DW'(out_err), DW'(0));
    drain();

    // Reset with two buffered words
    write_key(0, rnd128());
    out_ready = 1'b0;
    send_one(rnd128(), 0, 1'b0);
    send_one(rnd128(), 0, 1'b0);
    chk("pre_rst_full", DW'(exp_q.size()), DW'(2));
    rst = 1'b1;
    step();
    chk("mid_rst_valid", DW'(out_valid), DW'(0));
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    send_one(rnd128(), 0, 1'b0);
    chk("post_rst_err", DW'(out_err), DW'(1));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
